vga_scanner: RTL and testbench
==============================

# vga_scanner

Display-side consumer of the composed pixel stream. Generates pixel tick, raster counters and VGA sync timing, publishes the current pixel coordinate to the layer generators feeding the image composer, and registers the composer's 24-bit RGB result onto the VGA DAC pins, aligned with registered sync/blank. Sits between the image composer and the board's VGA connector.

## Interface
- CLK_DIV, 2: system clocks per pixel (≥1); 50 MHz / 2 = 25 MHz pixel rate
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- RGB_i  in  24  composed pixel for coordinate (x_o, y_o), {R[23:16],G[15:8],B[7:0]}; combinational from the composer, same cycle
- x_o  out  10  current horizontal counter
- y_o  out  10  current vertical counter
- active_o  out  1  1 when x_o < H_ACTIVE and y_o < V_ACTIVE
- pix_tick_o  out  1  one-clk_i pulse every CLK_DIV clocks; counters and output stage advance on it
- R_o, G_o, B_o  out  8 each  registered pixel to DAC
- hsync_o  out  1  registered, active-low
- vsync_o  out  1  registered, active-low
- blank_n_o  out  1  registered, 1 during visible pixels
- frame_start_o  out  1  one-clk_i pulse on the tick where counters wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: div counter 0..CLK_DIV-1; pix_tick_o = 1 when div == CLK_DIV-1. CLK_DIV=1 → tick every clock.
- On tick: h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 wraps to 0 on the same tick h wraps. x_o = h_cnt, y_o = v_cnt (zero-extended).
- Sync windows (from current counters): hsync low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751); vsync low for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output stage, loaded on tick only: {R_o,G_o,B_o} ← active_o ? RGB_i : 24'h0; hsync_o, vsync_o, blank_n_o ← decoded from current counters. Holds between ticks.
- RGB_i is never passed through during blanking; black is forced regardless of composer value.
- frame_start_o = pix_tick_o & (h_cnt == H_TOTAL-1) & (v_cnt == V_TOTAL-1).

## Timing
- Reset (rst_i high at a clk_i edge): div, h_cnt, v_cnt ← 0; R/G/B_o ← 0; hsync_o, vsync_o ← 1; blank_n_o ← 0; pix_tick_o, frame_start_o = 0 in the cycle after reset. Reset mid-frame restarts at (0,0) with no partial sync pulse continuing.
- Reset overrides tick in the same cycle.
- First tick after reset release: CLK_DIV clocks after the first non-reset edge (div reaches CLK_DIV-1).
- Coordinate-to-pin latency: exactly 1 pixel (1 tick). Pixel at (x,y) presented on x_o/y_o during pixel period k appears on R/G/B_o and its sync/blank on the pins during period k+1; sync and data stay mutually aligned.
- x_o/y_o/active_o change only on the clock edge that follows a tick; stable for CLK_DIV clocks.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks (840 000 with defaults).

## Test plan
- Reset then release, CLK_DIV=2: pix_tick_o high on every 2nd clock; x_o counts 0,1,2…; hsync_o=1, vsync_o=1, blank_n_o=0, RGB=0 until first tick loads (0,0).
- Drive RGB_i=24'h222222 constant: R/G/B_o = 22/22/22 for registered x 0..639, 0 for 640..799; blank_n_o low exactly 160 pixels per line.
- Line timing: hsync_o low for exactly 96 ticks, falling edge one tick after x_o=656; x_o wraps 799→0 with y_o incrementing.
- Frame timing: vsync_o low for 2 lines (registered y 490–491); frame_start_o single pulse per 840 000 clocks at (799,524)→(0,0).
- Drive RGB_i = {x_o[7:0], y_o[7:0], 8'h55}: output at pixel (10,3) equals 24'h0A0355 one tick later, confirming 1-pixel latency.
- Assert rst_i for 1 clock at x_o=300, y_o=200: next cycle counters 0,0, outputs at reset values, timing restarts cleanly; CLK_DIV=1 build repeats line test with tick every clock.

Source files
------------

// File: rtl/vga_scanner.sv
// vga_scanner: pixel-rate raster generator and VGA output stage.
// Divides clk_i down to a pixel tick, runs the horizontal/vertical counters,
// publishes the current coordinate to the layer generators, and registers the
// composed RGB value together with sync/blank so that pins stay aligned.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   RGB_i[23:0]    composed pixel for (x_o, y_o), {R,G,B}
//   x_o, y_o       current horizontal / vertical counter
//   active_o       current coordinate lies in the visible area
//   pix_tick_o     one-clock pulse per pixel period
//   R_o, G_o, B_o  registered pixel to DAC
//   hsync_o        registered horizontal sync, active-low
//   vsync_o        registered vertical sync, active-low
//   blank_n_o      registered, high during visible pixels
//   frame_start_o  pulse on the tick where counters wrap to (0,0)
module vga_scanner #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] RGB_i,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        active_o,
  output logic        pix_tick_o,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_n_o,
  output logic        frame_start_o
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          run;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [23:0]   pix;
  logic          tick;
  logic          active;
  logic          hsync_n;
  logic          vsync_n;

  // run holds the divider for the first clock out of reset so the first tick
  // lands CLK_DIV clocks after release, including CLK_DIV = 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
    end
  end

  assign tick = run & (div == DIV_LAST);

  // Raster counters; v advances on the same tick that h wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode from the current counters; registered below one tick later.
  always_comb begin
    active  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_n = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    vsync_n = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
  end

  // Output stage: black forced outside the visible area.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix       <= '0;
      hsync_o   <= 1'b1;
      vsync_o   <= 1'b1;
      blank_n_o <= 1'b0;
    end else if (tick) begin
      pix       <= active ? RGB_i : 24'h0;
      hsync_o   <= hsync_n;
      vsync_o   <= vsync_n;
      blank_n_o <= active;
    end
  end

  assign R_o           = pix[23:16];
  assign G_o           = pix[15:8];
  assign B_o           = pix[7:0];
  assign x_o           = h_cnt;
  assign y_o           = v_cnt;
  assign active_o      = active;
  assign pix_tick_o    = tick;
  assign frame_start_o = tick & (h_cnt == H_LAST) & (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_scanner.sv
// tb_vga_scanner: two scanners (CLK_DIV = 2 and 1) on a reduced raster,
// compared each clock against a tick-count based reference model.
module tb_vga_scanner;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk;
  logic rst;
  logic [23:0] rgb0, rgb1;
  logic [9:0]  x0, y0, x1, y1;
  logic        act0, act1, tk0, tk1, fs0, fs1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, bl0, hs1, vs1, bl1;

  vga_scanner #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut0 (
    .clk_i(clk), .rst_i(rst), .RGB_i(rgb0), .x_o(x0), .y_o(y0),
    .active_o(act0), .pix_tick_o(tk0), .R_o(r0), .G_o(g0), .B_o(b0),
    .hsync_o(hs0), .vsync_o(vs0), .blank_n_o(bl0), .frame_start_o(fs0));

  vga_scanner #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clk_i(clk), .rst_i(rst), .RGB_i(rgb1), .x_o(x1), .y_o(y1),
    .active_o(act1), .pix_tick_o(tk1), .R_o(r1), .G_o(g1), .B_o(b1),
    .hsync_o(hs1), .vsync_o(vs1), .blank_n_o(bl1), .frame_start_o(fs1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: k = clocks since the last reset edge, t = pixels
  // consumed, o_* = what the pins should show, px/py = pixel held on the pins.
  int   k [2];
  int   t [2];
  logic [23:0] o_rgb [2];
  logic o_hs [2], o_vs [2], o_bl [2];
  int   px [2], py [2];

  int ncyc    = 0;
  int mode    = 0;
  int last_fs = -1;
  int hs_run  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic tick_exp(input int i);
    return (k[i] > 0) && (k[i] % dv(i) == 0);
  endfunction

  task automatic model_edge(input int i, input logic r, input logic [23:0] din);
    int p, x, y;
    logic on;
    if (r) begin
      k[i] = 0; t[i] = 0; o_rgb[i] = 24'h0;
      o_hs[i] = 1'b1; o_vs[i] = 1'b1; o_bl[i] = 1'b0;
      px[i] = -1; py[i] = -1;
    end else begin
      if (tick_exp(i)) begin
        p = t[i] % FT;
        x = p % HT;
        y = p / HT;
        on = (x < HA) && (y < VA);
        o_rgb[i] = on ? din : 24'h0;
        o_hs[i]  = !((x >= HA + HF) && (x < HA + HF + HS));
        o_vs[i]  = !((y >= VA + VF) && (y < VA + VF + VS));
        o_bl[i]  = on;
        px[i] = x; py[i] = y;
        t[i]++;
      end
      k[i]++;
    end
  endtask

  task automatic compare_inst(input int i, input logic [9:0] x, input logic [9:0] y,
                              input logic act, input logic tk, input logic fs,
                              input logic [23:0] rgb, input logic hs, input logic vs,
                              input logic bl);
    int p, ex, ey;
    string pre;
    pre = (i == 0) ? "d0." : "d1.";
    p  = t[i] % FT;
    ex = p % HT;
    ey = p / HT;
    check({pre, "x"}, 32'(x), ex);
    check({pre, "y"}, 32'(y), ey);
    check({pre, "active"}, 32'(act), 32'((ex < HA) && (ey < VA)));
    check({pre, "tick"}, 32'(tk), 32'(tick_exp(i)));
    check({pre, "frame_start"}, 32'(fs), 32'(tick_exp(i) && (p == FT - 1)));
    check({pre, "rgb"}, 32'(rgb), 32'(o_rgb[i]));
    check({pre, "hsync"}, 32'(hs), 32'(o_hs[i]));
    check({pre, "vsync"}, 32'(vs), 32'(o_vs[i]));
    check({pre, "blank_n"}, 32'(bl), 32'(o_bl[i]));
  endtask

  function automatic logic [23:0] next_rgb(input int i);
    int p;
    logic [9:0] x, y;
    p = t[i] % FT;
    x = 10'(p % HT);
    y = 10'(p / HT);
    case (mode)
      1:       return 24'h222222;
      2:       return {x[7:0], y[7:0], 8'h55};
      default: return 24'($urandom);
    endcase
  endfunction

  // One clock: update the model at the edge, compare and drive at negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge(0, rst, rgb0);
    model_edge(1, rst, rgb1);
    ncyc++;
    if (rst) begin
      last_fs = -1;
      hs_run  = 0;
    end
    @(negedge clk);
    compare_inst(0, x0, y0, act0, tk0, fs0, {r0, g0, b0}, hs0, vs0, bl0);
    compare_inst(1, x1, y1, act1, tk1, fs1, {r1, g1, b1}, hs1, vs1, bl1);
    if (mode == 2 && px[0] == 10 && py[0] == 3)
      check("pix_10_3", 32'({r0, g0, b0}), 32'h0A0355);
    if (fs0) begin
      if (last_fs >= 0) check("frame_period", ncyc - last_fs, FT * 2);
      last_fs = ncyc;
    end
    if (tick_exp(0)) begin
      if (!hs0) hs_run++;
      else if (hs_run > 0) begin
        check("hsync_len", hs_run, HS);
        hs_run = 0;
      end
    end
    rgb0 = next_rgb(0);
    rgb1 = next_rgb(1);
  endtask

  initial begin
    bit found;
    rst  = 1'b1;
    rgb0 = 24'h0;
    rgb1 = 24'h0;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; t[i] = 0; o_rgb[i] = 24'h0;
      o_hs[i] = 1'b1; o_vs[i] = 1'b1; o_bl[i] = 1'b0; px[i] = -1; py[i] = -1;
    end
    repeat (3) cycle();
    rst = 1'b0;

    mode = 0;
    repeat (2 * FT * 2 + 50) cycle();
    mode = 1;
    repeat (FT * 2) cycle();
    mode = 2;
    repeat (FT * 2) cycle();

    // Mid-frame reset while the vertical sync pulse is running.
    mode  = 0;
    found = 1'b0;
    for (int n = 0; n < FT * 2 + 10 && !found; n++) begin
      if (tick_exp(0) == 1'b0 && (t[0] % FT) == 10 * HT + 20) found = 1'b1;
      else cycle();
    end
    check("reset_point_found", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (FT * 2 + 20) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
